// File: rtl/car_motion_scheduler_pkg.sv
// rtl/car_motion_scheduler_pkg.sv - shared geometry constants, FSM states and lane helpers
// for car_motion_scheduler (optional feature macro: CAR_LEVEL_RESET_EN).
package car_motion_scheduler_pkg;

  localparam int NUM_CARS   = 8;
  localparam int H_DISPLAY  = 640;
  localparam int CAR_SIZE   = 32;
  localparam int LANE_Y0    = 64;
  localparam int LANE_PITCH = 48;
  localparam int X_SPACING  = 80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    UPDATE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [9:0] init_x(input logic [2:0] idx);
    return 10'(int'(idx) * X_SPACING);
  endfunction

  function automatic logic [9:0] lane_y(input logic [2:0] idx);
    return 10'(LANE_Y0 + int'(idx) * LANE_PITCH);
  endfunction

endpackage

// File: rtl/car_motion_scheduler_if.sv
// rtl/car_motion_scheduler_if.sv - game-logic / renderer bus of car_motion_scheduler.
interface car_motion_scheduler_if;

  logic        frame_tick;
  logic        pause;
  logic [3:0]  current_level;
  logic [79:0] car_x_flat;
  logic [79:0] car_y_flat;
  logic        update_busy;
  logic        update_done;

  modport master (
    output frame_tick, pause, current_level,
    input  car_x_flat, car_y_flat, update_busy, update_done
  );

  modport slave (
    input  frame_tick, pause, current_level,
    output car_x_flat, car_y_flat, update_busy, update_done
  );

endinterface

// File: rtl/car_motion_scheduler_step_unit.sv
// rtl/car_motion_scheduler_step_unit.sv - shared combinational advance-and-wrap unit.
module car_step_unit
  import car_motion_scheduler_pkg::*;
(
  input  logic [9:0] x,
  input  logic [3:0] speed,
  input  logic       direction,
  output logic [9:0] next_x
);

  logic [10:0] sum;

  always_comb begin
    sum    = {1'b0, x} + {7'b0, speed};
    next_x = x;
    if (!direction) begin
      if (sum >= 11'(H_DISPLAY)) next_x = 10'(sum - 11'(H_DISPLAY));
      else                       next_x = sum[9:0];
    end else begin
      // Leftward underflow wraps to the right edge of the visible area
      if (x < {6'b0, speed}) next_x = 10'({1'b0, x} + 11'(H_DISPLAY) - {7'b0, speed});
      else                   next_x = x - {6'b0, speed};
    end
  end

endmodule

// File: rtl/car_motion_scheduler.sv
// rtl/car_motion_scheduler.sv - per-frame car position sequencer, one car per cycle
// through a shared step unit (optional feature macro: CAR_LEVEL_RESET_EN).
module car_motion_scheduler
  import car_motion_scheduler_pkg::*;
#(
  parameter int FRAME_DIV = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  car_motion_scheduler_if.slave  bus
);

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV);
  localparam logic [2:0] IDX_LAST = 3'(NUM_CARS - 1);

  state_t      state, state_next;
  logic [3:0]  div_cnt;
  logic [2:0]  idx;
  logic [3:0]  level_q;
  logic [9:0]  car_x [NUM_CARS];
  logic        accept, div_hit, active, reposition;
  logic [3:0]  speed;
  logic [9:0]  step_x;

  assign accept  = bus.frame_tick && !bus.pause && (state == IDLE);
  assign div_hit = (div_cnt + 4'd1) == DIV_LAST;
  assign speed   = 4'd1 + {2'b0, idx[1:0]} + {1'b0, level_q[3:1]};
  assign active  = {1'b0, idx} < level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next      = state;
    bus.update_busy = 1'b0;
    bus.update_done = 1'b0;
    case (state)
      IDLE:   if (accept && div_hit) state_next = LATCH;
      LATCH: begin
        bus.update_busy = 1'b1;
        state_next      = UPDATE;
      end
      UPDATE: begin
        bus.update_busy = 1'b1;
        if (idx == IDX_LAST) state_next = DONE;
      end
      DONE: begin
        bus.update_done = 1'b1;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       div_cnt <= 4'd0;
    else if (accept) div_cnt <= div_hit ? 4'd0 : div_cnt + 4'd1;
  end

  // level_q is frozen for the whole walk so mid-update level changes wait for the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= 4'd0;
      idx     <= 3'd0;
    end else if (state == LATCH) begin
      level_q <= bus.current_level;
      idx     <= 3'd0;
    end else if (state == UPDATE) begin
      idx <= idx + 3'd1;
    end
  end

`ifdef CAR_LEVEL_RESET_EN
  logic [3:0] prev_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_level <= 4'd0;
      reposition <= 1'b0;
    end else if (state == LATCH) begin
      reposition <= bus.current_level != prev_level;
    end else if (state == DONE) begin
      prev_level <= level_q;
    end
  end
`else
  assign reposition = 1'b0;
`endif

  car_step_unit u_step (
    .x         (car_x[idx]),
    .speed     (speed),
    .direction (idx[0]),
    .next_x    (step_x)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CARS; i++) car_x[i] <= init_x(3'(i));
    end else if (state == UPDATE) begin
      if (reposition)  car_x[idx] <= init_x(idx);
      else if (active) car_x[idx] <= step_x;
    end
  end

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_flat
    assign bus.car_x_flat[10*g +: 10] = car_x[g];
    assign bus.car_y_flat[10*g +: 10] = lane_y(3'(g));
  end

endmodule

// File: tb/tb_car_motion_scheduler.sv
// tb/tb_car_motion_scheduler.sv - randomized self-checking bench for car_motion_scheduler.
module tb_car_motion_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   mx [8];
  int   prev_lvl;

  always #5 clk = ~clk;

  car_motion_scheduler_if bus ();
  car_motion_scheduler_if bus3 ();

  car_motion_scheduler #(.FRAME_DIV(1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  car_motion_scheduler #(.FRAME_DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mx[i] = i * 80;
    prev_lvl = 0;
  endfunction

  function automatic void model_frame(input int lvl);
`ifdef CAR_LEVEL_RESET_EN
    if (lvl != prev_lvl) begin
      for (int i = 0; i < 8; i++) mx[i] = i * 80;
      prev_lvl = lvl;
      return;
    end
`endif
    for (int i = 0; i < 8; i++) begin
      if (i < lvl) begin
        int s;
        s = 1 + (i % 4) + lvl / 2;
        if (i % 2 == 0) mx[i] = (mx[i] + s) % 640;
        else            mx[i] = (mx[i] + 640 - s) % 640;
      end
    end
  endfunction

  function automatic logic [79:0] model_flat();
    logic [79:0] r;
    for (int i = 0; i < 8; i++) r[10*i +: 10] = 10'(mx[i]);
    return r;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Pulses one tick on the FRAME_DIV=1 instance and watches the next 13 cycles
  task automatic do_frame(input logic [3:0] lvl, input logic pz, input int extra_at,
                          output int ndone, output int first_done, output int busy_err);
    @(negedge clk);
    bus.current_level = lvl;
    bus.pause         = pz;
    bus.frame_tick    = 1'b1;
    ndone = 0; first_done = -1; busy_err = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.frame_tick = (c == extra_at);
      bus.pause      = 1'b0;
      if (c == 2) bus.current_level = 4'($urandom_range(0, 15));
      if (bus.update_done === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = c;
      end
      if (bus.update_busy !== (!pz && c <= 9)) busy_err++;
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if (bus.car_x_flat[39:30] !== 10'd240) begin
      tests_failed++; $display("FAIL reset_x3 got %0d want 240", bus.car_x_flat[39:30]);
    end
    tests_run++;
    if (bus.car_y_flat[39:30] !== 10'd208) begin
      tests_failed++; $display("FAIL reset_y3 got %0d want 208", bus.car_y_flat[39:30]);
    end
    tests_run++;
    if (bus.car_y_flat[79:70] !== 10'd400) begin
      tests_failed++; $display("FAIL reset_y7 got %0d want 400", bus.car_y_flat[79:70]);
    end
    tests_run++;
    if (bus.update_busy !== 1'b0 || bus.update_done !== 1'b0) begin
      tests_failed++; $display("FAIL reset_flags busy=%b done=%b want 0 0", bus.update_busy, bus.update_done);
    end
    tests_run++;
    if (bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL reset_all_x got %h want %h", bus.car_x_flat, model_flat());
    end
  endtask

  task automatic test_single();
    int nd, fd, be;
    apply_reset();
    do_frame(4'd8, 1'b0, 0, nd, fd, be);
    model_frame(8);
    tests_run++;
    if (nd != 1 || fd != 10) begin
      tests_failed++; $display("FAIL single_done count=%0d at=%0d want 1 at 10", nd, fd);
    end
    tests_run++;
    if (be != 0) begin
      tests_failed++; $display("FAIL single_busy errors=%0d want 0", be);
    end
    tests_run++;
    if (bus.car_x_flat[9:0] !== 10'(mx[0]) || bus.car_x_flat[19:10] !== 10'(mx[1])) begin
      tests_failed++; $display("FAIL single_car01 got %0d,%0d want %0d,%0d",
                               bus.car_x_flat[9:0], bus.car_x_flat[19:10], mx[0], mx[1]);
    end
    tests_run++;
    if (bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL single_all_x got %h want %h", bus.car_x_flat, model_flat());
    end
  endtask

  task automatic test_partial();
    int nd, fd, be;
    apply_reset();
    do_frame(4'd2, 1'b0, 0, nd, fd, be);
    model_frame(2);
    tests_run++;
    if (bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL partial_x got %h want %h", bus.car_x_flat, model_flat());
    end
    for (int i = 2; i < 8; i++) begin
      tests_run++;
      if (bus.car_x_flat[10*i +: 10] !== 10'(i * 80)) begin
        tests_failed++; $display("FAIL partial_hold car%0d got %0d want %0d", i, bus.car_x_flat[10*i +: 10], i * 80);
      end
    end
  endtask

  task automatic test_dropped();
    int nd, fd, be;
    do_frame(4'd8, 1'b0, 4, nd, fd, be);
    model_frame(8);
    tests_run++;
    if (nd != 1 || fd != 10 || bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL drop_busy_tick done=%0d at=%0d x=%h want 1 at 10 x=%h",
                               nd, fd, bus.car_x_flat, model_flat());
    end
    do_frame(4'd8, 1'b1, 0, nd, fd, be);
    tests_run++;
    if (nd != 0 || be != 0 || bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL drop_pause done=%0d busy_err=%0d x=%h want 0 0 x=%h",
                               nd, be, bus.car_x_flat, model_flat());
    end
  endtask

  task automatic test_frame_div();
    int nd;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      bus3.current_level = 4'd8;
      bus3.frame_tick    = 1'b1;
      nd = 0;
      for (int c = 1; c <= 13; c++) begin
        @(negedge clk);
        bus3.frame_tick = 1'b0;
        if (bus3.update_done === 1'b1) nd++;
      end
      tests_run++;
      if (nd != ((k % 3 == 0) ? 1 : 0)) begin
        tests_failed++; $display("FAIL frame_div tick%0d done=%0d want %0d", k, nd, (k % 3 == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd, fd, be, lvl;
    logic pz;
    for (int n = 0; n < 200; n++) begin
      lvl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 15));
      pz  = ($urandom_range(0, 7) == 0);
      do_frame(4'(lvl), pz, 0, nd, fd, be);
      if (!pz) model_frame(lvl);
      tests_run++;
      if (nd != (pz ? 0 : 1) || be != 0 || bus.car_x_flat !== model_flat()) begin
        tests_failed++; $display("FAIL random frame%0d lvl=%0d pause=%b done=%0d busy_err=%0d x=%h want x=%h",
                                 n, lvl, pz, nd, be, bus.car_x_flat, model_flat());
      end
    end
  endtask

  task automatic test_reset_mid();
    int nd;
    @(negedge clk);
    bus.current_level = 4'd8;
    bus.frame_tick    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
    reset = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (bus.car_x_flat !== model_flat() || bus.update_busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid x=%h busy=%b want x=%h busy=0", bus.car_x_flat, bus.update_busy, model_flat());
    end
    @(negedge clk);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.update_done === 1'b1) nd++;
    end
    tests_run++;
    if (nd != 0 || bus.car_x_flat !== model_flat()) begin
      tests_failed++; $display("FAIL reset_mid_after done=%0d x=%h want 0 x=%h", nd, bus.car_x_flat, model_flat());
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.pause = 1'b0; bus.current_level = 4'd0;
    bus3.frame_tick = 1'b0; bus3.pause = 1'b0; bus3.current_level = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_div();
    test_single();
    test_partial();
    test_dropped();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/car_motion_scheduler.md
Name: car_motion_scheduler

Overview:
- Sequences the per-frame position update of the 8 car sprites consumed by the VGA display logic.
- On each frame-start pulse, it walks the cars one per cycle through a single shared adder/wrap unit.
- Each car advances by a level-dependent speed; even lanes move right, odd lanes move left, with horizontal wrap-around.
- It sits between the game/level logic and the renderer and drives the car_x/car_y inputs of the renderer.

Parameters:
- NUM_CARS, 8, number of cars/lanes scheduled; fixed at 8 for the renderer.
- H_DISPLAY, 640, visible width; X wraps modulo this value.
- LANE_Y0, 64, Y of lane 0.
- LANE_PITCH, 48, vertical spacing between lanes.
- X_SPACING, 80, initial X spacing between cars.
- FRAME_DIV, 1, update on every FRAME_DIV-th accepted frame tick (1..15).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- frame_tick  in  1  single-cycle pulse at start of vertical blank
- pause  in  1  when high, frame ticks are ignored
- current_level  in  4  game level; car i moves only if i < current_level
- car_x_flat  out  80  car i X at bits [10*i+9:10*i]
- car_y_flat  out  80  car i Y at bits [10*i+9:10*i], constant after reset
- update_busy  out  1  high from the LATCH state through the last UPDATE cycle
- update_done  out  1  one-cycle pulse when a frame update completes

Behaviour:
- Reset (async, active-high, any time including mid-update):
  - car_x[i] = i*X_SPACING; car_y[i] = LANE_Y0 + i*LANE_PITCH.
  - State IDLE; divider count 0; update_busy = 0; update_done = 0.
- States:
  - IDLE: waits for an accepted tick.
  - LATCH: captures current_level into level_q; car index = 0.
  - UPDATE: one car per cycle, index 0..NUM_CARS-1.
  - DONE: update_done = 1 for one cycle, then returns to IDLE.
- Accepted tick: frame_tick=1 AND pause=0 AND state IDLE.
  - Ticks in any other state, or with pause=1, are dropped silently.
- Divider:
  - Each accepted tick increments the divider.
  - Only the tick that makes the count reach FRAME_DIV enters LATCH, and the count resets to 0.
  - Other accepted ticks leave the state at IDLE.
- Latency: tick at cycle T means LATCH at T+1, car i written at the end of cycle T+2+i, update_done high in cycle T+10.
- Speed: speed_i = 1 + (i mod 4) + (level_q >> 1), 4-bit unsigned, maximum 11.
- Right-moving cars (i even):
  - If x + speed >= H_DISPLAY, x = x + speed - H_DISPLAY; else x = x + speed.
  - Computed at 11 bits.
- Left-moving cars (i odd): if x < speed, x = x + H_DISPLAY - speed; else x = x - speed.
- Inactive cars (i >= level_q): X is held, but the UPDATE slot is still consumed, so latency is fixed.
- level_q = 0: no car moves, but update_done still pulses.
- current_level changing during UPDATE has no effect until the next LATCH.
- Y outputs never change after reset.

Optional Feature:
- Macro: CAR_LEVEL_RESET_EN.
- Defined:
  - A register prev_level holds level_q from the last completed update.
  - If LATCH captures a value different from prev_level, every UPDATE slot writes that car's reset X instead of advancing it.
  - prev_level reset value is 0.
- Not defined: positions always advance; level changes never reposition cars.

Decomposition:
- Shared package/include holds:
  - H_DISPLAY, CAR_SIZE (32), LANE_Y0, LANE_PITCH, X_SPACING.
  - State encodings IDLE/LATCH/UPDATE/DONE.
- One natural sub-module, car_step_unit: combinational.
  - Inputs: x, speed, direction.
  - Output: wrapped next x.
  - This is the single shared adder the FSM time-multiplexes across cars.

Test Plan:
- Reset then idle → car_x[3]=240, car_y[3]=208, car_y[7]=400, update_busy=0, update_done=0.
- current_level=8, one frame_tick at T:
  - car0 X 0→5 and car1 X 80→74 (speed 6, leftward).
  - update_done high only at T+10.
- Wrap, level 8:
  - car0 at 638 → 3 after one update.
  - car1 at 4 → 638 after one update.
- current_level=2, one tick → only cars 0 and 1 change; cars 2..7 keep 160,240,...,560.
- Dropped ticks:
  - Second frame_tick at T+4 → ignored, exactly one update_done.
  - Tick with pause=1 → no state change, no update_done.
  - FRAME_DIV=3 → update_done after every 3rd tick only.
- Reset asserted mid-UPDATE at T+5 → same cycle (async) all X return to i*80, busy=0, and no update_done follows.
